// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - weight tile read sequencer for the systolic array
// Issues W_ROWS reads per tile, waits out the column skew, then holds tile_ready until compute_done.
module weight_load_ctrl #(
  parameter int SYS_COLS = 3,
  parameter int W_ROWS   = 3,
  parameter int TILE_W   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [TILE_W-1:0]             num_tiles_i,
  input  logic                          stall_i,
  input  logic                          compute_done_i,
  output logic                          rd_o,
  output logic [$clog2(W_ROWS+1)-1:0]   row_idx_o,
  output logic [TILE_W-1:0]             tile_idx_o,
  output logic                          tile_ready_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int RW = $clog2(W_ROWS + 1);
  localparam int DW = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
  localparam logic [RW-1:0] ROWS_FULL  = RW'(W_ROWS);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((SYS_COLS > 1) ? SYS_COLS - 2 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, WAIT, DONE} state_e;

  state_e             state_q;
  logic [RW-1:0]      row_idx_q, row_idx_d;
  logic [TILE_W-1:0]  tile_idx_q, tile_idx_d, num_q;
  logic [DW-1:0]      drain_q;
  logic               tile_ready_q, busy_q, done_q;
  logic               last_tile;

  // Read strobe is combinational so a stall suppresses the beat in the same cycle.
  assign rd_o       = (state_q == LOAD) && !stall_i;
  assign row_idx_d  = (row_idx_q == ROWS_FULL) ? row_idx_q : row_idx_q + RW'(1);
  assign tile_idx_d = tile_idx_q + TILE_W'(1);
  assign last_tile  = (tile_idx_q == num_q - TILE_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      row_idx_q    <= '0;
      tile_idx_q   <= '0;
      num_q        <= '0;
      drain_q      <= '0;
      tile_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            num_q      <= num_tiles_i;
            tile_idx_q <= '0;
            row_idx_q  <= '0;
            busy_q     <= 1'b1;
            if (num_tiles_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (!stall_i) begin
            row_idx_q <= row_idx_d;
            if (row_idx_d == ROWS_FULL) begin
              drain_q <= '0;
              if (SYS_COLS == 1) begin
                state_q      <= WAIT;
                tile_ready_q <= 1'b1;
              end else begin
                state_q <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q      <= WAIT;
            tile_ready_q <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        WAIT: begin
          if (compute_done_i) begin
            tile_ready_q <= 1'b0;
            row_idx_q    <= '0;
            if (last_tile) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              tile_idx_q <= tile_idx_d;
              state_q    <= LOAD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign row_idx_o    = row_idx_q;
  assign tile_idx_o   = tile_idx_q;
  assign tile_ready_o = tile_ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - self-checking bench for weight_load_ctrl
// Table vectors, directed corner sequences and random stimulus against a countdown model.
module tb_weight_load_ctrl;

  localparam int SYS_COLS = 3;
  localparam int W_ROWS   = 3;
  localparam int TILE_W   = 8;

  logic              clk = 1'b0;
  logic              rst, start, stall, cd;
  logic [TILE_W-1:0] num;
  logic              rd, ready, busy, done;
  logic [1:0]        row_idx;
  logic [TILE_W-1:0] tile_idx;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference: counts of remaining work rather than an encoded state.
  int m_active, m_load, m_drain, m_wait, m_done, m_rows, m_tile, m_n;

  weight_load_ctrl #(.SYS_COLS(SYS_COLS), .W_ROWS(W_ROWS), .TILE_W(TILE_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_tiles_i(num), .stall_i(stall),
    .compute_done_i(cd), .rd_o(rd), .row_idx_o(row_idx), .tile_idx_o(tile_idx),
    .tile_ready_o(ready), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s; logic [7:0] n; logic c;
    logic e_rd; int e_row; int e_tile; logic e_rdy; logic e_busy; logic e_done;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic model_tick();
    if (rst) begin
      m_active = 0; m_load = 0; m_drain = 0; m_wait = 0; m_done = 0;
      m_rows = 0; m_tile = 0; m_n = 0;
    end else if (m_active == 0) begin
      if (start) begin
        m_n = num; m_tile = 0; m_rows = 0; m_active = 1;
        if (num == 0) m_done = 1; else m_load = 1;
      end
    end else if (m_done != 0) begin
      m_done = 0; m_active = 0;
    end else if (m_load != 0) begin
      if (!stall) begin
        m_rows++;
        if (m_rows == W_ROWS) begin
          m_load = 0;
          if (SYS_COLS > 1) m_drain = SYS_COLS - 1; else m_wait = 1;
        end
      end
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_wait = 1;
    end else if (m_wait != 0 && cd) begin
      m_wait = 0; m_rows = 0;
      if (m_tile == m_n - 1) m_done = 1;
      else begin m_tile++; m_load = 1; end
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic [7:0] n,
                       input logic st, input logic c);
    rst = r; start = s; num = n; stall = st; cd = c;
    #1;
    if (chk_en) begin
      chk("rd",         32'(rd),       32'((m_load != 0) && !st));
      chk("row_idx",    32'(row_idx),  32'(m_rows));
      chk("tile_idx",   32'(tile_idx), 32'(m_tile));
      chk("tile_ready", 32'(ready),    32'(m_wait));
      chk("busy",       32'(busy),     32'(m_active));
      chk("done",       32'(done),     32'(m_done));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    apply(1, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0); tick();
    chk_en = 1;
  endtask

  initial begin
    int rd_cnt, done_cnt, wc, seen, first_rdy, busy_cnt;
    logic [15:0] rd_mask;
    logic c;

    rst = 1; start = 0; stall = 0; cd = 0; num = 0;
    // start@0 num=1, compute_done@8; num_tiles changes after start must be ignored.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 5, 0, 1, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 5, 0, 1, 1, 0, 0, 1, 0};
    tbl[3]  = '{0, 5, 0, 1, 2, 0, 0, 1, 0};
    tbl[4]  = '{0, 5, 0, 0, 3, 0, 0, 1, 0};
    tbl[5]  = '{0, 5, 0, 0, 3, 0, 0, 1, 0};
    tbl[6]  = '{0, 5, 0, 0, 3, 0, 1, 1, 0};
    tbl[7]  = '{0, 5, 0, 0, 3, 0, 1, 1, 0};
    tbl[8]  = '{0, 5, 1, 0, 3, 0, 1, 1, 0};
    tbl[9]  = '{0, 5, 0, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{0, 5, 0, 0, 0, 0, 0, 0, 0};

    @(negedge clk);
    reset_dut();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_row", 32'(row_idx), 32'd0);

    for (int i = 0; i < 11; i++) begin
      apply(0, tbl[i].s, tbl[i].n, 0, tbl[i].c);
      chk("tbl_rd",    32'(rd),       32'(tbl[i].e_rd));
      chk("tbl_row",   32'(row_idx),  32'(tbl[i].e_row));
      chk("tbl_tile",  32'(tile_idx), 32'(tbl[i].e_tile));
      chk("tbl_ready", 32'(ready),    32'(tbl[i].e_rdy));
      chk("tbl_busy",  32'(busy),     32'(tbl[i].e_busy));
      chk("tbl_done",  32'(done),     32'(tbl[i].e_done));
      tick();
    end

    // Two tiles, compute_done two cycles after each tile_ready.
    reset_dut();
    rd_cnt = 0; done_cnt = 0; wc = 0; seen = 0;
    for (int t = 0; t < 40; t++) begin
      c = (m_wait != 0) && (wc == 2);
      apply(0, t == 0, 2, 0, c);
      rd_cnt += int'(rd); done_cnt += int'(done);
      if (ready && wc == 0) begin
        chk("tile_at_ready", 32'(tile_idx), 32'(seen));
        seen++;
      end
      wc = (m_wait != 0) ? wc + 1 : 0;
      tick();
    end
    chk("two_tile_rd_beats", 32'(rd_cnt), 32'd6);
    chk("two_tile_done_pulses", 32'(done_cnt), 32'd1);
    chk("two_tile_ready_count", 32'(seen), 32'd2);

    // Stall in cycles 2-3 of LOAD.
    reset_dut();
    rd_mask = '0; first_rdy = -1;
    for (int t = 0; t < 12; t++) begin
      apply(0, t == 0, 1, (t == 2 || t == 3), t == 10);
      rd_mask[t] = rd;
      if ((t == 2 || t == 3)) chk("stall_row_hold", 32'(row_idx), 32'd1);
      if (ready && first_rdy < 0) first_rdy = t;
      tick();
    end
    chk("stall_rd_cycles", 32'(rd_mask), 32'h0032);
    chk("stall_ready_rise", 32'(first_rdy), 32'd8);

    // num_tiles == 0.
    reset_dut();
    rd_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int t = 0; t < 5; t++) begin
      apply(0, t == 0, 0, 0, 0);
      rd_cnt += int'(rd); busy_cnt += int'(busy); done_cnt += int'(done);
      if (t == 1) chk("zero_done_next", 32'(done), 32'd1);
      tick();
    end
    chk("zero_no_rd", 32'(rd_cnt), 32'd0);
    chk("zero_busy_cycles", 32'(busy_cnt), 32'd1);
    chk("zero_done_count", 32'(done_cnt), 32'd1);

    // Stray compute_done in LOAD/DRAIN and start while busy are ignored.
    reset_dut();
    rd_cnt = 0; first_rdy = -1; done_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      apply(0, (t == 0 || t == 3), (t == 3) ? 8'd7 : 8'd1, 0, (t == 2 || t == 5 || t == 8));
      rd_cnt += int'(rd);
      if (ready && first_rdy < 0) first_rdy = t;
      if (t == 9) chk("ignored_done_at_9", 32'(done), 32'd1);
      done_cnt += int'(done);
      tick();
    end
    chk("ignored_rd_beats", 32'(rd_cnt), 32'd3);
    chk("ignored_ready_rise", 32'(first_rdy), 32'd6);
    chk("ignored_done_count", 32'(done_cnt), 32'd1);

    // Reset while draining, then a fresh full tile.
    reset_dut();
    for (int t = 0; t < 6; t++) begin
      apply(t == 4, t == 0, 1, 0, 0);
      if (t == 5) begin
        chk("rst_drain_busy", 32'(busy), 32'd0);
        chk("rst_drain_row", 32'(row_idx), 32'd0);
        chk("rst_drain_rd", 32'(rd), 32'd0);
      end
      tick();
    end
    rd_cnt = 0; first_rdy = -1;
    for (int t = 0; t < 10; t++) begin
      apply(0, t == 0, 1, 0, t == 8);
      rd_cnt += int'(rd);
      if (ready && first_rdy < 0) first_rdy = t;
      tick();
    end
    chk("restart_rd_beats", 32'(rd_cnt), 32'd3);
    chk("restart_ready_rise", 32'(first_rdy), 32'd6);

    // Random traffic against the model.
    reset_dut();
    for (int t = 0; t < 600; t++) begin
      apply($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
            8'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
